pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 106 ++++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC sequencer with redirect/flush/halt handling and a
// circular return-address stack.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [15:0] redir_target,
    input  logic [15:0] redir_link,
    input  logic        halt,
    output logic [15:0] pc,
    output logic        flush,
    output logic        halted,
    output logic        ras_empty,
    output logic        ras_full,
    output logic [1:0]  ras_err
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_q, err_d;
    logic [15:0]   ras_q [RAS_DEPTH];
    logic [PW-1:0] top_idx;
    logic          push;
    logic          redir;

    assign redir     = redir_valid && (redir_type != 2'b11);
    assign top_idx   = ptr_q - PW'(1);
    assign pc        = pc_q;
    assign flush     = (state_q == FLUSH);
    assign halted    = (state_q == HALT);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == FULL);
    assign ras_err   = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        push    = 1'b0;
        case (state_q)
            RUN: begin
                if (redir) begin
                    state_d = FLUSH;
                    if (redir_type == 2'b10) begin
                        pc_d  = ras_empty ? redir_target : ras_q[top_idx];
                        ptr_d = ras_empty ? ptr_q : top_idx;
                        cnt_d = ras_empty ? cnt_q : cnt_q - 1'b1;
                        err_d = err_q | {1'b0, ras_empty};
                    end else begin
                        pc_d = redir_target;
                        if (redir_type == 2'b01) begin
                            // Full stack: overwrite the oldest entry, which sits at ptr.
                            push  = 1'b1;
                            ptr_d = ptr_q + PW'(1);
                            cnt_d = ras_full ? cnt_q : cnt_q + 1'b1;
                            err_d = err_q | {ras_full, 1'b0};
                        end
                    end
                end else if (halt) begin
                    state_d = HALT;
                end else if (!stall) begin
                    pc_d = pc_q + 16'd1;
                end
            end
            FLUSH: begin
                state_d = RUN;
                pc_d    = stall ? pc_q : pc_q + 16'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) ras_q[ptr_q] <= redir_link;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: random + directed stimulus against a queue-based reference
// model; expectations go through a scoreboard checked by a separate monitor.
module tb_pc_sequencer;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0, redir_valid = 1'b0, halt = 1'b0;
    logic [1:0]  redir_type = 2'b00;
    logic [15:0] redir_target = '0, redir_link = '0;
    logic [15:0] pc;
    logic        flush, halted, ras_empty, ras_full;
    logic [1:0]  ras_err;

    pc_sequencer #(.RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redir_valid(redir_valid),
        .redir_type(redir_type), .redir_target(redir_target), .redir_link(redir_link),
        .halt(halt), .pc(pc), .flush(flush), .halted(halted),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        fl, hl, em, fu;
        logic [1:0]  err;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_pc;
    logic        m_flush, m_halt;
    logic [1:0]  m_err;
    logic [15:0] m_ras [$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("flush", 16'(flush), 16'(e.fl));
            chk("halted", 16'(halted), 16'(e.hl));
            chk("ras_empty", 16'(ras_empty), 16'(e.em));
            chk("ras_full", 16'(ras_full), 16'(e.fu));
            chk("ras_err", 16'(ras_err), 16'(e.err));
        end
    end

    function automatic void model_reset();
        m_pc = RST_PC;
        m_flush = 1'b0;
        m_halt = 1'b0;
        m_err = 2'b00;
        m_ras.delete();
    endfunction

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic cyc(input logic rv, input logic [1:0] rt, input logic [15:0] tgt,
                       input logic [15:0] lnk, input logic hl, input logic st);
        exp_t e;
        redir_valid = rv; redir_type = rt; redir_target = tgt;
        redir_link = lnk; halt = hl; stall = st;
        if (m_halt) begin
        end else if (m_flush) begin
            m_flush = 1'b0;
            if (!st) m_pc = m_pc + 16'd1;
        end else if (rv && rt != 2'b11) begin
            m_flush = 1'b1;
            if (rt == 2'b00) m_pc = tgt;
            else if (rt == 2'b01) begin
                m_pc = tgt;
                m_ras.push_back(lnk);
                if (m_ras.size() > DEPTH) begin
                    m_ras.delete(0);
                    m_err[1] = 1'b1;
                end
            end else if (m_ras.size() == 0) begin
                m_pc = tgt;
                m_err[0] = 1'b1;
            end else m_pc = m_ras.pop_back();
        end else if (hl) m_halt = 1'b1;
        else if (!st) m_pc = m_pc + 16'd1;
        e.pc = m_pc; e.fl = m_flush; e.hl = m_halt;
        e.em = (m_ras.size() == 0); e.fu = (m_ras.size() == DEPTH); e.err = m_err;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse away from any rising edge; values must appear at once.
    task automatic async_rst();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_flush", 16'(flush), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);
        chk("rst_empty", 16'(ras_empty), 16'd1);
        chk("rst_err", 16'(ras_err), 16'd0);
        model_reset();
        redir_valid = 1'b0; halt = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        async_rst();
        idle(3);
        chk("pc_after_3_idle", pc, 16'h0003);
        cyc(1'b1, 2'b00, 16'h000F, 16'h0000, 1'b0, 1'b0);
        idle(1);
        cyc(1'b1, 2'b00, 16'h0040, 16'h0000, 1'b0, 1'b1);
        chk("redir_over_stall", pc, 16'h0040);
        idle(1);
        cyc(1'b1, 2'b01, 16'h0100, 16'h0011, 1'b0, 1'b0);
        idle(5);
        cyc(1'b1, 2'b10, 16'hDEAD, 16'h0000, 1'b0, 1'b0);
        chk("return_pc", pc, 16'h0011);
        chk("return_err", 16'(ras_err), 16'd0);
        idle(1);
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 2'b01, 16'h0400 + 16'(i), 16'(i), 1'b0, 1'b0);
            idle(1);
        end
        chk("ovf_err", 16'(ras_err), 16'd2);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 2'b10, 16'h0777, 16'h0000, 1'b0, 1'b0);
            if (i == 0) chk("first_ret", pc, 16'h0005);
            idle(1);
        end
        chk("both_err", 16'(ras_err), 16'd3);
        cyc(1'b1, 2'b00, 16'hFFFE, 16'h0000, 1'b0, 1'b0);
        idle(2);
        chk("wrap", pc, 16'h0000);
        cyc(1'b1, 2'b00, 16'h001E, 16'h0000, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 2'(i), 16'h0900, 16'h0901, 1'b0, 1'b0);
        chk("halt_pc", pc, 16'h0020);
        async_rst();
        cyc(1'b1, 2'b00, 16'h0300, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 16'h0200, 16'h0000, 1'b0, 1'b0);
        chk("flush_ignores_redir", pc, 16'h0301);
        cyc(1'b1, 2'b11, 16'h0500, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 2'b00, 16'h0600, 16'h0000, 1'b0, 1'b0);
        async_rst();
        idle(1);
        for (int n = 0; n < 600; n++) begin
            if (m_halt && $urandom_range(0, 3) == 0) async_rst();
            else if ($urandom_range(0, 99) == 0) async_rst();
            else cyc($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), 16'($urandom),
                     16'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
        end
        idle(1);
        chk("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
